// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed restoring divider, one quotient bit per clock
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    counter;
  logic [WIDTH:0]   rem;      // partial remainder, one spare bit so the borrow is kept
  logic [WIDTH-1:0] dq;       // dividend shifts out the top, quotient bits enter the bottom
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             start_exc;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] q_next;
  logic             last_step;

  // Operand magnitudes and the exception decode for a start in this cycle;
  // the most negative value negates to itself, which is its correct unsigned magnitude
  always_comb begin
    abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    start_exc = (data_operandB == '0) ||
                ((data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1));
  end

  // One restoring step: shift {rem, dividend} left, keep the trial difference when it does not borrow
  always_comb begin
    shifted   = {rem, dq[WIDTH-1]};
    trial     = shifted - {2'b00, dvs};
    trial_ok  = ~trial[WIDTH+1];
    rem_next  = trial_ok ? trial[WIDTH:0] : shifted[WIDTH:0];
    q_next    = {dq[WIDTH-2:0], trial_ok};
    last_step = (counter == CW'(WIDTH - 1));
  end

  // Control FSM and datapath registers; result fields are registered and held between completions
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      counter        <= '0;
      rem            <= '0;
      dq             <= '0;
      dvs            <= '0;
      sign_q         <= 1'b0;
      sign_r         <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (ctrl_DIV) begin
            dq      <= abs_a;
            dvs     <= abs_b;
            sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            sign_r  <= data_operandA[WIDTH-1];
            rem     <= '0;
            counter <= '0;
            if (start_exc) begin
              state          <= S_DONE;
              busy           <= 1'b0;
              data_result    <= '0;
              data_remainder <= '0;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_RUN: begin
          rem     <= rem_next;
          dq      <= q_next;
          counter <= counter + 1'b1;
          if (last_step) begin
            state          <= S_DONE;
            busy           <= 1'b0;
            data_result    <= sign_q ? -q_next : q_next;
            data_remainder <= sign_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
            data_exception <= 1'b0;
            data_resultRDY <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and random self-checking bench for seq_divider
module tb_seq_divider;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int tests_run;
  int tests_failed;
  logic prev_rdy;

  seq_divider #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ready must never be high in two consecutive cycles
  always @(negedge clock) begin
    if (data_resultRDY) check("rdy_single_cycle", {63'd0, prev_rdy}, 64'd0);
    prev_rdy = data_resultRDY;
  end

  // Called #1 after a rising edge; the next edge is the start edge
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Counts edges from the current point until ready is seen, with a cycle budget
  task automatic wait_rdy(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!data_resultRDY && lat < 100) begin
      if (busy) busy_n++;
      @(posedge clock);
      #1;
      lat++;
    end
    if (lat >= 100) check("rdy_timeout", 64'd1, 64'd0);
  endtask

  task automatic idle_cycle();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] va [9];
  logic [31:0] vb [9];
  logic [31:0] vq [9];
  logic [31:0] vr [9];
  logic        ve [9];

  initial begin
    int lat;
    int bn;
    int sa, sb;
    logic [31:0] ra, rb;

    tests_run = 0;
    tests_failed = 0;
    prev_rdy = 1'b0;
    reset_n = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;

    va[0] = 32'd100;       vb[0] = 32'd7;          vq[0] = 32'd14;         vr[0] = 32'd2;          ve[0] = 1'b0;
    va[1] = 32'hFFFFFF9C;  vb[1] = 32'd7;          vq[1] = 32'hFFFFFFF2;   vr[1] = 32'hFFFFFFFE;   ve[1] = 1'b0;
    va[2] = 32'd100;       vb[2] = 32'hFFFFFFF9;   vq[2] = 32'hFFFFFFF2;   vr[2] = 32'd2;          ve[2] = 1'b0;
    va[3] = 32'hFFFFFF9C;  vb[3] = 32'hFFFFFFF9;   vq[3] = 32'd14;         vr[3] = 32'hFFFFFFFE;   ve[3] = 1'b0;
    va[4] = 32'h80000000;  vb[4] = 32'd2;          vq[4] = 32'hC0000000;   vr[4] = 32'd0;          ve[4] = 1'b0;
    va[5] = 32'h80000000;  vb[5] = 32'd1;          vq[5] = 32'h80000000;   vr[5] = 32'd0;          ve[5] = 1'b0;
    va[6] = 32'd5;         vb[6] = 32'd0;          vq[6] = 32'd0;          vr[6] = 32'd0;          ve[6] = 1'b1;
    va[7] = 32'h80000000;  vb[7] = 32'hFFFFFFFF;   vq[7] = 32'd0;          vr[7] = 32'd0;          ve[7] = 1'b1;
    va[8] = 32'd0;         vb[8] = 32'd5;          vq[8] = 32'd0;          vr[8] = 32'd0;          ve[8] = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_result", {32'd0, data_result}, 64'd0);
    check("reset_rem", {32'd0, data_remainder}, 64'd0);
    check("reset_flags", {61'd0, data_exception, data_resultRDY, busy}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    idle_cycle();

    // basic case with latency, busy length and hold
    launch(32'd100, 32'd7);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    wait_rdy(lat, bn);
    check("lat_100_7", lat, 64'd32);
    check("busy_cycles", bn, 64'd32);
    check("q_100_7", {32'd0, data_result}, 64'd14);
    check("r_100_7", {32'd0, data_remainder}, 64'd2);
    check("e_100_7", {63'd0, data_exception}, 64'd0);
    repeat (3) idle_cycle();
    check("hold_q", {32'd0, data_result}, 64'd14);
    check("hold_r", {32'd0, data_remainder}, 64'd2);
    check("hold_rdy_low", {63'd0, data_resultRDY}, 64'd0);

    // directed signed and exception vectors
    for (int i = 0; i < 9; i++) begin
      launch(va[i], vb[i]);
      wait_rdy(lat, bn);
      check($sformatf("lat_v%0d", i), lat, ve[i] ? 64'd0 : 64'd32);
      check($sformatf("q_v%0d", i), {32'd0, data_result}, {32'd0, vq[i]});
      check($sformatf("r_v%0d", i), {32'd0, data_remainder}, {32'd0, vr[i]});
      check($sformatf("e_v%0d", i), {63'd0, data_exception}, {63'd0, ve[i]});
      idle_cycle();
      idle_cycle();
    end

    // start ignored mid-run, then back-to-back start from DONE
    launch(32'd1000, 32'd10);
    repeat (9) @(posedge clock);
    #1;
    data_operandA = 32'd1;
    data_operandB = 32'd1;
    ctrl_DIV = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    wait_rdy(lat, bn);
    check("lat_ignore", lat, 64'd22);
    check("q_ignore", {32'd0, data_result}, 64'd100);
    check("r_ignore", {32'd0, data_remainder}, 64'd0);
    launch(32'd9, 32'd3);
    check("b2b_busy", {63'd0, busy}, 64'd1);
    wait_rdy(lat, bn);
    check("lat_b2b", lat, 64'd32);
    check("q_b2b", {32'd0, data_result}, 64'd3);
    check("r_b2b", {32'd0, data_remainder}, 64'd0);
    idle_cycle();

    // asynchronous reset in the middle of a run
    launch(32'd1000, 32'd10);
    repeat (14) @(posedge clock);
    #4;
    reset_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_q", {32'd0, data_result}, 64'd0);
    check("arst_r", {32'd0, data_remainder}, 64'd0);
    check("arst_rdy", {63'd0, data_resultRDY}, 64'd0);
    bn = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (i == 2) reset_n = 1'b1;
      if (data_resultRDY) bn++;
    end
    check("arst_no_rdy", bn, 64'd0);
    launch(32'd7, 32'd2);
    wait_rdy(lat, bn);
    check("q_post_rst", {32'd0, data_result}, 64'd3);
    check("r_post_rst", {32'd0, data_remainder}, 64'd1);
    idle_cycle();

    // random operands against truncating / and %
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? ($urandom % 1000) : $urandom;
      if (i % 4 == 1) rb = -rb;
      if (rb == 32'd0) rb = 32'd3;
      if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd5;
      sa = ra;
      sb = rb;
      launch(ra, rb);
      wait_rdy(lat, bn);
      check($sformatf("lat_rand%0d", i), lat, 64'd32);
      check($sformatf("q_rand%0d", i), {32'd0, data_result}, {32'd0, 32'(sa / sb)});
      check($sformatf("r_rand%0d", i), {32'd0, data_remainder}, {32'd0, 32'(sa % sb)});
      check($sformatf("e_rand%0d", i), {63'd0, data_exception}, 64'd0);
      idle_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
